// File: rtl/mem_slave.sv
// On-chip memory bus slave: parametrised width/depth, programmable wait states,
// optional byte-enabled writes (RAM mode) and an error response for illegal accesses.
module mem_slave #(
  parameter int    ADDR_W      = 11,
  parameter int    DATA_W      = 32,
  parameter int    DEPTH       = 2048,
  parameter int    WAIT_STATES = 0,
  parameter int    WRITABLE    = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  CS_,
  input  logic                  As_,
  input  logic                  RW,
  input  logic [ADDR_W-1:0]     Addr,
  input  logic [DATA_W-1:0]     WrData,
  input  logic [DATA_W/8-1:0]   BE,
  output logic [DATA_W-1:0]     RdData,
  output logic                  Rdy_,
  output logic                  Err_
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               rw_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [NB-1:0]      be_q;
  logic               rdy_q, err_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               accept, go, in_range, acc_err;
  logic [ADDR_W-1:0]  acc_addr;
  logic               acc_rw;
  logic [DATA_W-1:0]  acc_wdata;
  logic [NB-1:0]      acc_be;
  logic [IDX_W-1:0]   idx;

  assign accept = (state_q == IDLE) && !CS_ && !As_;

  // Zero wait states serve the request straight from the bus on the accepting
  // edge; otherwise the latched copy is used when the counter expires.
  always_comb begin
    if (WAIT_STATES == 0) begin
      acc_addr  = Addr;
      acc_rw    = RW;
      acc_wdata = WrData;
      acc_be    = BE;
      go        = reset_ && accept;
    end else begin
      acc_addr  = addr_q;
      acc_rw    = rw_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      go        = reset_ && (state_q == WAIT) && (cnt_q == 4'd0);
    end
  end

  assign in_range = 32'(acc_addr) < 32'(DEPTH);
  assign acc_err  = (!acc_rw && (WRITABLE == 0)) || !in_range;
  assign idx      = acc_addr[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept && (WAIT_STATES > 0)) begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
      WAIT: if (cnt_q == 4'd0) state_d = IDLE;
            else cnt_d = cnt_q - 4'd1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b1;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= !go;
      err_q   <= !(go && acc_err);
      // Out-of-range accesses of either kind clear the read data.
      if (go && (acc_rw || !in_range))
        rdata_q <= in_range ? mem_q[idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= Addr;
      rw_q    <= RW;
      wdata_q <= WrData;
      be_q    <= BE;
    end
  end

  generate
    if (WRITABLE != 0) begin : g_ram
      always_ff @(posedge clk) begin
        if (go && !acc_rw && in_range) begin
          for (int i = 0; i < NB; i++)
            if (acc_be[i]) mem_q[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end else begin : g_rom
      logic unused_wr;
      assign unused_wr = ^{acc_wdata, acc_be};
    end
  endgenerate

  assign RdData = rdata_q;
  assign Rdy_   = rdy_q;
  assign Err_   = err_q;

endmodule

// File: tb/tb_mem_slave.sv
// Scoreboard bench for mem_slave: three instances (zero-wait ROM, 3-wait ROM,
// 5-wait RAM) on a shared bus with separate chip selects.
module tb_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_;
  logic        As_, RW;
  logic [10:0] Addr;
  logic [31:0] WrData;
  logic [3:0]  BE;
  logic        cs_rom_n, cs_ws_n, cs_ram_n;
  logic [31:0] rd_rom, rd_ws, rd_ram;
  logic        rdy_rom, rdy_ws, rdy_ram;
  logic        err_rom, err_ws, err_ram;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
    logic [31:0] cyc;
  } resp_t;

  resp_t exp_q[$];
  resp_t obs_q[$];
  int    cyc = 0;
  int    viol = 0;
  int    chk_cnt = 0;
  int    pass_cnt = 0;

  logic [31:0] rom_m [4];
  logic [31:0] rom_rd;
  logic [31:0] ram2, ram_rd;

  mem_slave #(.DEPTH(1000), .WAIT_STATES(0), .WRITABLE(0)) u_rom (
    .clk(clk), .reset_(reset_), .CS_(cs_rom_n), .As_(As_), .RW(RW), .Addr(Addr),
    .WrData(WrData), .BE(BE), .RdData(rd_rom), .Rdy_(rdy_rom), .Err_(err_rom));

  mem_slave #(.WAIT_STATES(3), .WRITABLE(0)) u_ws (
    .clk(clk), .reset_(reset_), .CS_(cs_ws_n), .As_(As_), .RW(RW), .Addr(Addr),
    .WrData(WrData), .BE(BE), .RdData(rd_ws), .Rdy_(rdy_ws), .Err_(err_ws));

  mem_slave #(.WAIT_STATES(5), .WRITABLE(1)) u_ram (
    .clk(clk), .reset_(reset_), .CS_(cs_ram_n), .As_(As_), .RW(RW), .Addr(Addr),
    .WrData(WrData), .BE(BE), .RdData(rd_ram), .Rdy_(rdy_ram), .Err_(err_ram));

  always @(posedge clk) cyc <= cyc + 1;

  // Record every response strobe; the tasks compare against the expectations.
  always @(negedge clk) begin
    if (rdy_rom === 1'b0) obs_q.push_back('{2'd0, rd_rom, err_rom, 32'(cyc)});
    if (rdy_ws  === 1'b0) obs_q.push_back('{2'd1, rd_ws,  err_ws,  32'(cyc)});
    if (rdy_ram === 1'b0) obs_q.push_back('{2'd2, rd_ram, err_ram, 32'(cyc)});
    if (reset_ === 1'b1 && ((rdy_rom === 1'b1 && err_rom !== 1'b1) ||
        (rdy_ws === 1'b1 && err_ws !== 1'b1) || (rdy_ram === 1'b1 && err_ram !== 1'b1)))
      viol++;
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // id 3 selects no slave at all.
  task automatic strobe(input logic [1:0] id, input logic rw, input logic [10:0] a,
                        input logic [31:0] wd, input logic [3:0] be, output int e0);
    cs_rom_n = (id != 2'd0);
    cs_ws_n  = (id != 2'd1);
    cs_ram_n = (id != 2'd2);
    As_ = 1'b0; RW = rw; Addr = a; WrData = wd; BE = be;
    @(posedge clk); #1;
    e0 = cyc;
    As_ = 1'b1; cs_rom_n = 1'b1; cs_ws_n = 1'b1; cs_ram_n = 1'b1;
    RW = 1'($urandom); Addr = 11'($urandom); WrData = $urandom; BE = 4'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_ = 1'b1;
    #2 reset_ = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++;
    if ({rdy_rom, rdy_ws, rdy_ram} !== 3'b111) $display("FAIL reset_rdy: got %b, expected 111", {rdy_rom, rdy_ws, rdy_ram});
    else pass_cnt++;
    chk_cnt++;
    if ({err_rom, err_ws, err_ram} !== 3'b111) $display("FAIL reset_err: got %b, expected 111", {err_rom, err_ws, err_ram});
    else pass_cnt++;
    chk_cnt++;
    if ({rd_rom, rd_ws, rd_ram} !== 96'd0) $display("FAIL reset_rddata: got %h, expected 0", {rd_rom, rd_ws, rd_ram});
    else pass_cnt++;
    @(posedge clk); #1 reset_ = 1'b1;
    $display("reset checked");
  endtask

  task automatic test_read_latency;
    int e0;
    resp_t e, o;
    strobe(2'd0, 1'b1, 11'd5, 32'd0, 4'h0, e0);
    exp_q.push_back('{2'd0, 32'hDEADBEEF, 1'b1, 32'(e0)});
    for (int i = 0; i < 4; i++) begin
      strobe(2'd0, 1'b1, 11'(i), 32'd0, 4'h0, e0);
      exp_q.push_back('{2'd0, rom_m[i], 1'b1, 32'(e0)});
    end
    rom_rd = rom_m[3];
    idle(2);
    chk_cnt++;
    if (obs_q.size() != exp_q.size()) $display("FAIL latency_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); chk_cnt++;
      if (o !== e) $display("FAIL latency_resp: got id=%0d data=%h err=%b cyc=%0d, expected id=%0d data=%h err=%b cyc=%0d", o.id, o.data, o.err, o.cyc, e.id, e.data, e.err, e.cyc);
      else begin pass_cnt++; $display("resp id=%0d data=%h err=%b cyc=%0d", o.id, o.data, o.err, o.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_wait_states;
    int e0, e1, en;
    resp_t e, o;
    strobe(2'd1, 1'b1, 11'd7, 32'd0, 4'h0, e0);
    exp_q.push_back('{2'd1, 32'hCAFE0007, 1'b1, 32'(e0 + 3)});
    strobe(2'd1, 1'b1, 11'd8, 32'd0, 4'h0, en);   // lands in WAIT and must vanish
    idle(2);
    strobe(2'd1, 1'b1, 11'd9, 32'd0, 4'h0, e1);   // accepted in the Rdy_ cycle
    exp_q.push_back('{2'd1, 32'h99999999, 1'b1, 32'(e1 + 3)});
    idle(5);
    chk_cnt++;
    if (obs_q.size() != exp_q.size()) $display("FAIL wait_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); chk_cnt++;
      if (o !== e) $display("FAIL wait_resp: got id=%0d data=%h err=%b cyc=%0d, expected id=%0d data=%h err=%b cyc=%0d", o.id, o.data, o.err, o.cyc, e.id, e.data, e.err, e.cyc);
      else begin pass_cnt++; $display("resp id=%0d data=%h err=%b cyc=%0d", o.id, o.data, o.err, o.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_byte_write;
    int e0;
    resp_t e, o;
    logic [31:0] wd [4] = '{32'h11223344, 32'hAABBCCDD, 32'h0, 32'hFFFFFFFF};
    logic [3:0]  be [4] = '{4'hF, 4'b0101, 4'h0, 4'h0};
    ram_rd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      strobe(2'd2, 1'b0, 11'd2, wd[i], be[i], e0);
      exp_q.push_back('{2'd2, ram_rd, 1'b1, 32'(e0 + 5)});
      ram2 = (i == 0) ? wd[i] : merge(ram2, wd[i], be[i]);
      idle(5);
      if (i != 0) begin
        strobe(2'd2, 1'b1, 11'd2, 32'd0, 4'h0, e0);
        exp_q.push_back('{2'd2, ram2, 1'b1, 32'(e0 + 5)});
        ram_rd = ram2;
        idle(5);
      end
    end
    idle(1);
    chk_cnt++;
    if (obs_q.size() != exp_q.size()) $display("FAIL bytewr_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); chk_cnt++;
      if (o !== e) $display("FAIL bytewr_resp: got id=%0d data=%h err=%b cyc=%0d, expected id=%0d data=%h err=%b cyc=%0d", o.id, o.data, o.err, o.cyc, e.id, e.data, e.err, e.cyc);
      else begin pass_cnt++; $display("resp id=%0d data=%h err=%b cyc=%0d", o.id, o.data, o.err, o.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_errors;
    int e0;
    resp_t e, o;
    strobe(2'd0, 1'b0, 11'd1, 32'h12345678, 4'hF, e0);
    exp_q.push_back('{2'd0, rom_rd, 1'b0, 32'(e0)});
    strobe(2'd0, 1'b1, 11'd1, 32'd0, 4'h0, e0);
    exp_q.push_back('{2'd0, rom_m[1], 1'b1, 32'(e0)});
    strobe(2'd0, 1'b1, 11'd999, 32'd0, 4'h0, e0);
    exp_q.push_back('{2'd0, 32'h00000999, 1'b1, 32'(e0)});
    strobe(2'd0, 1'b1, 11'd1000, 32'd0, 4'h0, e0);
    exp_q.push_back('{2'd0, 32'h0, 1'b0, 32'(e0)});
    strobe(2'd0, 1'b1, 11'd999, 32'd0, 4'h0, e0);
    exp_q.push_back('{2'd0, 32'h00000999, 1'b1, 32'(e0)});
    strobe(2'd0, 1'b1, 11'd1500, 32'd0, 4'h0, e0);
    exp_q.push_back('{2'd0, 32'h0, 1'b0, 32'(e0)});
    idle(2);
    chk_cnt++;
    if (obs_q.size() != exp_q.size()) $display("FAIL err_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); chk_cnt++;
      if (o !== e) $display("FAIL err_resp: got id=%0d data=%h err=%b cyc=%0d, expected id=%0d data=%h err=%b cyc=%0d", o.id, o.data, o.err, o.cyc, e.id, e.data, e.err, e.cyc);
      else begin pass_cnt++; $display("resp id=%0d data=%h err=%b cyc=%0d", o.id, o.data, o.err, o.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid;
    int e0;
    resp_t e, o;
    strobe(2'd2, 1'b1, 11'd2, 32'd0, 4'h0, e0);
    exp_q.push_back('{2'd2, ram2, 1'b1, 32'(e0 + 5)});
    idle(6);
    strobe(2'd2, 1'b0, 11'd2, 32'h55555555, 4'hF, e0);
    @(posedge clk); #1 reset_ = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (rdy_ram !== 1'b1) $display("FAIL midrst_rdy: got %b, expected 1", rdy_ram);
    else pass_cnt++;
    chk_cnt++;
    if (err_ram !== 1'b1) $display("FAIL midrst_err: got %b, expected 1", err_ram);
    else pass_cnt++;
    chk_cnt++;
    if (rd_ram !== 32'h0) $display("FAIL midrst_rddata: got %h, expected 0", rd_ram);
    else pass_cnt++;
    @(posedge clk); #1 reset_ = 1'b1;
    strobe(2'd2, 1'b1, 11'd2, 32'd0, 4'h0, e0);
    exp_q.push_back('{2'd2, ram2, 1'b1, 32'(e0 + 5)});
    ram_rd = ram2;
    idle(6);
    chk_cnt++;
    if (obs_q.size() != exp_q.size()) $display("FAIL midrst_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); chk_cnt++;
      if (o !== e) $display("FAIL midrst_resp: got id=%0d data=%h err=%b cyc=%0d, expected id=%0d data=%h err=%b cyc=%0d", o.id, o.data, o.err, o.cyc, e.id, e.data, e.err, e.cyc);
      else begin pass_cnt++; $display("resp id=%0d data=%h err=%b cyc=%0d", o.id, o.data, o.err, o.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_cs_gating;
    int e0;
    resp_t e, o;
    strobe(2'd3, 1'b0, 11'd2, 32'h77777777, 4'hF, e0);
    idle(7);
    chk_cnt++;
    if (obs_q.size() != 0) $display("FAIL cs_norsp: got %0d responses, expected 0", obs_q.size());
    else pass_cnt++;
    chk_cnt++;
    if (rd_ram !== ram_rd) $display("FAIL cs_rddata: got %h, expected %h", rd_ram, ram_rd);
    else pass_cnt++;
    obs_q.delete();
    strobe(2'd2, 1'b1, 11'd2, 32'd0, 4'h0, e0);
    exp_q.push_back('{2'd2, ram2, 1'b1, 32'(e0 + 5)});
    idle(6);
    chk_cnt++;
    if (obs_q.size() != exp_q.size()) $display("FAIL cs_count: got %0d responses, expected %0d", obs_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); chk_cnt++;
      if (o !== e) $display("FAIL cs_resp: got id=%0d data=%h err=%b cyc=%0d, expected id=%0d data=%h err=%b cyc=%0d", o.id, o.data, o.err, o.cyc, e.id, e.data, e.err, e.cyc);
      else begin pass_cnt++; $display("resp id=%0d data=%h err=%b cyc=%0d", o.id, o.data, o.err, o.cyc); end
    end
    exp_q.delete(); obs_q.delete();
    chk_cnt++;
    if (viol !== 0) $display("FAIL err_outside_rdy: got %0d cycles with Err_ low while Rdy_ high, expected 0", viol);
    else pass_cnt++;
  endtask

  initial begin
    As_ = 1'b1; RW = 1'b1; Addr = '0; WrData = '0; BE = '0;
    cs_rom_n = 1'b1; cs_ws_n = 1'b1; cs_ram_n = 1'b1;
    ram2 = 32'h0; ram_rd = 32'h0; rom_rd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      rom_m[i] = 32'hA5000000 | 32'(i * 32'h01010101);
      u_rom.mem_q[i] = rom_m[i];
    end
    u_rom.mem_q[1]   = rom_m[1];
    u_rom.mem_q[5]   = 32'hDEADBEEF;
    u_rom.mem_q[999] = 32'h00000999;
    u_ws.mem_q[7]    = 32'hCAFE0007;
    u_ws.mem_q[8]    = 32'h88888888;
    u_ws.mem_q[9]    = 32'h99999999;

    test_reset;
    test_read_latency;
    test_wait_states;
    test_byte_write;
    test_errors;
    test_reset_mid;
    test_cs_gating;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
